// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS32 datapath: memory map,
// opcode/funct encodings, register-number names, status-flag bit indices
// and the internal ALU operation selector.
package mips_pkg;

    // Memory map
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE = 32'h1001_0000;
    localparam logic [31:0] SP_RESET  = 32'h1001_03FC;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Register numbers
    localparam logic [4:0] zero = 5'd0;
    localparam logic [4:0] at   = 5'd1;
    localparam logic [4:0] v0   = 5'd2;
    localparam logic [4:0] a0   = 5'd4;
    localparam logic [4:0] t0   = 5'd8;
    localparam logic [4:0] t1   = 5'd9;
    localparam logic [4:0] t2   = 5'd10;
    localparam logic [4:0] t3   = 5'd11;
    localparam logic [4:0] t4   = 5'd12;
    localparam logic [4:0] t5   = 5'd13;
    localparam logic [4:0] t6   = 5'd14;
    localparam logic [4:0] t7   = 5'd15;
    localparam logic [4:0] s0   = 5'd16;
    localparam logic [4:0] s1   = 5'd17;
    localparam logic [4:0] s2   = 5'd18;
    localparam logic [4:0] s3   = 5'd19;
    localparam logic [4:0] s4   = 5'd20;
    localparam logic [4:0] s5   = 5'd21;
    localparam logic [4:0] s6   = 5'd22;
    localparam logic [4:0] s7   = 5'd23;
    localparam logic [4:0] sp   = 5'd29;
    localparam logic [4:0] ra   = 5'd31;

    // Status register bit positions
    localparam int STATUS_C_BIT = 0;
    localparam int STATUS_Z_BIT = 1;
    localparam int STATUS_N_BIT = 2;
    localparam int STATUS_V_BIT = 3;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_single_cycle_datapath_register_file.sv
// 32x32 register file: two asynchronous read ports, one write port that
// commits on the rising clock edge. Register 0 reads as zero and ignores
// writes. Reset clears every register except $sp, which gets SP_RESET.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   rs_addr_i/rs_data_o   read port A
//   rt_addr_i/rt_data_o   read port B
//   we_i, wa_i, wd_i      write enable, address, data
module register_file
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);

    logic [31:0] data [0:31];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                data[i] <= (5'(i) == sp) ? SP_RESET : 32'h0;
            end
        end else if (we_i && (wa_i != zero)) begin
            data[wa_i] <= wd_i;
        end
    end

    // Reads see the pre-edge contents, so a same-cycle write is not bypassed.
    assign rs_data_o = (rs_addr_i == zero) ? 32'h0 : data[rs_addr_i];
    assign rt_data_o = (rt_addr_i == zero) ? 32'h0 : data[rt_addr_i];

endmodule

// File: rtl/mips_single_cycle_datapath.sv
// Single-cycle MIPS32 integer datapath. Fetch, decode, register read, ALU,
// data-memory access and next-PC selection are combinational; pc, the
// register file and the optional status register update on the rising edge.
// Optional feature macro: STATUS_FLAGS_EN adds a 4-bit V/N/Z/C status_reg.
// Ports:
//   clock           system clock
//   insReadValue    instruction word at insMemAddress
//   dataReadValue   data word at dataMemAddress
//   insMemAddress   current pc
//   insMemRead      always 1
//   dataMemAddress  ALU result (effective address for lw/sw)
//   dataMemRead     high for lw (forced low during reset)
//   dataMemWrite    high for sw (forced low during reset)
//   dataWriteValue  rt contents for sw
//   reset           synchronous active-high reset
module mips_single_cycle_datapath
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic [31:0] insReadValue,
    input  logic [31:0] dataReadValue,
    output logic [31:0] insMemAddress,
    output logic        insMemRead,
    output logic [31:0] dataMemAddress,
    output logic        dataMemRead,
    output logic        dataMemWrite,
    output logic [31:0] dataWriteValue,
    input  logic        reset
);

    logic [31:0] pc;
    logic [31:0] reg_nextPC;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] extended;
    logic [31:0] aluOut;

    logic [31:0] rs_val;
    logic [31:0] rt_val;

    // Control
    alu_op_e     alu_op;
    logic        alu_b_imm;
    logic        zero_ext;
    logic        shift_var;
    logic        reg_we;
    logic [4:0]  dest;
    logic        wb_mem;
    logic        wb_link;
    logic        mem_rd;
    logic        mem_wr;
    logic        flag_upd;
    logic        is_beq;
    logic        is_bne;
    logic        is_j;
    logic        is_jr;

    // ALU internals
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  sa;
    logic [32:0] sum;
    logic [32:0] diff;
    logic        alu_c;
    logic        alu_v;
    logic [31:0] wb_data;

    assign opcode   = insReadValue[31:26];
    assign rs       = insReadValue[25:21];
    assign rt       = insReadValue[20:16];
    assign rd       = insReadValue[15:11];
    assign shamt    = insReadValue[10:6];
    assign funct    = insReadValue[5:0];
    assign extended = ext_imm(insReadValue[15:0], zero_ext);
    assign pc_plus4 = pc + 32'd4;

    register_file rf (
        .clk_i     (clock),
        .rst_i     (reset),
        .rs_addr_i (rs),
        .rt_addr_i (rt),
        .rs_data_o (rs_val),
        .rt_data_o (rt_val),
        .we_i      (reg_we),
        .wa_i      (dest),
        .wd_i      (wb_data)
    );

    // Decode: undefined encodings keep all defaults and behave as a NOP.
    always_comb begin
        alu_op    = ALU_ADD;
        alu_b_imm = 1'b0;
        zero_ext  = 1'b0;
        shift_var = 1'b0;
        reg_we    = 1'b0;
        dest      = rt;
        wb_mem    = 1'b0;
        wb_link   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        flag_upd  = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        is_jr     = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dest     = rd;
                reg_we   = 1'b1;
                flag_upd = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
                    FN_JR: begin
                        is_jr    = 1'b1;
                        reg_we   = 1'b0;
                        flag_upd = 1'b0;
                    end
                    default: begin
                        reg_we   = 1'b0;
                        flag_upd = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_b_imm = 1'b1; reg_we = 1'b1; flag_upd = 1'b1;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT; alu_b_imm = 1'b1; reg_we = 1'b1; flag_upd = 1'b1;
            end
            OP_SLTIU: begin
                alu_op = ALU_SLTU; alu_b_imm = 1'b1; reg_we = 1'b1; flag_upd = 1'b1;
            end
            OP_ANDI: begin
                alu_op = ALU_AND; alu_b_imm = 1'b1; zero_ext = 1'b1;
                reg_we = 1'b1; flag_upd = 1'b1;
            end
            OP_ORI: begin
                alu_op = ALU_OR; alu_b_imm = 1'b1; zero_ext = 1'b1;
                reg_we = 1'b1; flag_upd = 1'b1;
            end
            OP_XORI: begin
                alu_op = ALU_XOR; alu_b_imm = 1'b1; zero_ext = 1'b1;
                reg_we = 1'b1; flag_upd = 1'b1;
            end
            OP_LUI: begin
                alu_op = ALU_LUI; alu_b_imm = 1'b1; reg_we = 1'b1; flag_upd = 1'b1;
            end
            OP_LW: begin
                alu_b_imm = 1'b1; reg_we = 1'b1; wb_mem = 1'b1; mem_rd = 1'b1;
            end
            OP_SW: begin
                alu_b_imm = 1'b1; mem_wr = 1'b1;
            end
            OP_BEQ: is_beq = 1'b1;
            OP_BNE: is_bne = 1'b1;
            OP_J:   is_j   = 1'b1;
            OP_JAL: begin
                is_j = 1'b1; reg_we = 1'b1; dest = ra; wb_link = 1'b1;
            end
            default: ;
        endcase
    end

    // Execute
    assign alu_a = rs_val;
    assign alu_b = alu_b_imm ? extended : rt_val;
    assign sa    = shift_var ? rs_val[4:0] : shamt;
    assign sum   = {1'b0, alu_a} + {1'b0, alu_b};
    // Subtract as a + ~b + 1 so bit 32 is the inverted borrow.
    assign diff  = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;

    always_comb begin
        aluOut = sum[31:0];
        alu_c  = 1'b0;
        alu_v  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                aluOut = sum[31:0];
                alu_c  = sum[32];
                alu_v  = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
            end
            ALU_SUB: begin
                aluOut = diff[31:0];
                alu_c  = diff[32];
                alu_v  = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            ALU_AND:  aluOut = alu_a & alu_b;
            ALU_OR:   aluOut = alu_a | alu_b;
            ALU_XOR:  aluOut = alu_a ^ alu_b;
            ALU_NOR:  aluOut = ~(alu_a | alu_b);
            ALU_SLT:  aluOut = {31'h0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: aluOut = {31'h0, alu_a < alu_b};
            ALU_SLL:  aluOut = alu_b << sa;
            ALU_SRL:  aluOut = alu_b >> sa;
            ALU_SRA:  aluOut = $unsigned($signed(alu_b) >>> sa);
            ALU_LUI:  aluOut = {alu_b[15:0], 16'h0000};
            default:  aluOut = sum[31:0];
        endcase
    end

    // Next PC
    always_comb begin
        reg_nextPC = pc_plus4;
        if (is_jr) begin
            reg_nextPC = rs_val;
        end else if (is_j) begin
            reg_nextPC = {pc_plus4[31:28], insReadValue[25:0], 2'b00};
        end else if ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val))) begin
            reg_nextPC = pc_plus4 + (extended << 2);
        end
    end

    // Memory / write-back
    assign wb_data        = wb_link ? pc_plus4 : (wb_mem ? dataReadValue : aluOut);
    assign insMemAddress  = pc;
    assign insMemRead     = 1'b1;
    assign dataMemAddress = aluOut;
    assign dataMemRead    = mem_rd & ~reset;
    assign dataMemWrite   = mem_wr & ~reset;
    assign dataWriteValue = rt_val;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= TEXT_BASE;
        end else begin
            pc <= reg_nextPC;
        end
    end

`ifdef STATUS_FLAGS_EN
    logic [3:0] status_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            status_reg <= 4'h0;
        end else if (flag_upd) begin
            status_reg[STATUS_V_BIT] <= alu_v;
            status_reg[STATUS_N_BIT] <= aluOut[31];
            status_reg[STATUS_Z_BIT] <= (aluOut == 32'h0);
            status_reg[STATUS_C_BIT] <= alu_c;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = alu_c ^ alu_v ^ flag_upd;
`endif

endmodule

// File: tb/tb_mips_single_cycle_datapath.sv
module tb_mips_single_cycle_datapath;
    import mips_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] insReadValue;
    logic [31:0] dataReadValue;
    logic [31:0] insMemAddress;
    logic        insMemRead;
    logic [31:0] dataMemAddress;
    logic        dataMemRead;
    logic        dataMemWrite;
    logic [31:0] dataWriteValue;

    int vectors     = 0;
    int miscompares = 0;

    mips_single_cycle_datapath dut (
        .clock          (clock),
        .insReadValue   (insReadValue),
        .dataReadValue  (dataReadValue),
        .insMemAddress  (insMemAddress),
        .insMemRead     (insMemRead),
        .dataMemAddress (dataMemAddress),
        .dataMemRead    (dataMemRead),
        .dataMemWrite   (dataMemWrite),
        .dataWriteValue (dataWriteValue),
        .reset          (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment memories
    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:255] = '{default: 32'h0};
    logic [31:0] i_off;
    logic [31:0] d_off;

    assign i_off         = insMemAddress - TEXT_BASE;
    assign d_off         = dataMemAddress - DATA_BASE;
    assign insReadValue  = (i_off < 32'd512)  ? imem[i_off[8:2]] : 32'h0;
    assign dataReadValue = (d_off < 32'd1024) ? dmem[d_off[9:2]] : 32'h0;

    always @(posedge clock) begin
        if (dataMemWrite && (d_off < 32'd1024)) dmem[d_off[9:2]] <= dataWriteValue;
    end

    // Architectural reference model
    logic [31:0] m_regs [0:31];
    logic [31:0] m_mem  [0:255] = '{default: 32'h0};
    logic [31:0] m_pc;
    logic        m_v, m_n, m_z, m_c;
    bit          model_ok = 0;

    function automatic logic [31:0] imem_at(input logic [31:0] a);
        logic [31:0] off;
        off = a - TEXT_BASE;
        return (off < 32'd512) ? imem[off[8:2]] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_regs[29] = SP_RESET;
        m_pc = TEXT_BASE;
        m_v = 0; m_n = 0; m_z = 0; m_c = 0;
    endtask

    task automatic model_exec();
        logic [31:0] ins, a, b, se, ze, res, npc, opnd, off;
        logic [5:0]  op, fn;
        logic [4:0]  rsn, rtn, rdn, sh, dst;
        bit          wr, fl;
        int          kind;
        longint      sres;
        longint      lim;
        lim = 2147483647;
        ins = imem_at(m_pc);
        op  = ins[31:26]; rsn = ins[25:21]; rtn = ins[20:16];
        rdn = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a   = m_regs[rsn]; b = m_regs[rtn];
        se  = {{16{ins[15]}}, ins[15:0]};
        ze  = {16'h0, ins[15:0]};
        npc = m_pc + 32'd4;
        res = 32'h0; wr = 0; fl = 0; kind = 0; dst = rtn; opnd = se;
        off = a + se - DATA_BASE;
        case (op)
            6'h00: begin
                dst = rdn; wr = 1; fl = 1; opnd = b;
                case (fn)
                    6'h20, 6'h21: begin res = a + b; kind = 1; end
                    6'h22, 6'h23: begin res = a - b; kind = 2; end
                    6'h24: res = a & b;
                    6'h25: res = a | b;
                    6'h26: res = a ^ b;
                    6'h27: res = ~(a | b);
                    6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                    6'h00: res = b << sh;
                    6'h02: res = b >> sh;
                    6'h03: res = $unsigned($signed(b) >>> sh);
                    6'h04: res = b << a[4:0];
                    6'h06: res = b >> a[4:0];
                    6'h07: res = $unsigned($signed(b) >>> a[4:0]);
                    6'h08: begin npc = a; wr = 0; fl = 0; end
                    default: begin wr = 0; fl = 0; end
                endcase
            end
            6'h08, 6'h09: begin res = a + se; kind = 1; wr = 1; fl = 1; end
            6'h0A: begin res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; wr = 1; fl = 1; end
            6'h0B: begin res = (a < se) ? 32'd1 : 32'd0; wr = 1; fl = 1; end
            6'h0C: begin res = a & ze; wr = 1; fl = 1; end
            6'h0D: begin res = a | ze; wr = 1; fl = 1; end
            6'h0E: begin res = a ^ ze; wr = 1; fl = 1; end
            6'h0F: begin res = {ins[15:0], 16'h0}; wr = 1; fl = 1; end
            6'h23: begin res = (off < 32'd1024) ? m_mem[off[9:2]] : 32'h0; wr = 1; end
            6'h2B: if (off < 32'd1024) m_mem[off[9:2]] = b;
            6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
            6'h05: if (a != b) npc = m_pc + 32'd4 + (se << 2);
            6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
            6'h03: begin
                npc = {npc[31:28], ins[25:0], 2'b00};
                res = m_pc + 32'd4; dst = 5'd31; wr = 1;
            end
            default: ;
        endcase
        if (fl) begin
            m_z = (res == 32'h0); m_n = res[31]; m_c = 0; m_v = 0;
            if (kind == 1) begin
                m_c  = ({32'h0, a} + {32'h0, opnd}) > 64'hFFFF_FFFF;
                sres = longint'($signed(a)) + longint'($signed(opnd));
                m_v  = (sres > lim) || (sres < -lim - 1);
            end else if (kind == 2) begin
                m_c  = (a >= opnd);
                sres = longint'($signed(a)) - longint'($signed(opnd));
                m_v  = (sres > lim) || (sres < -lim - 1);
            end
        end
        if (wr && dst != 5'd0) m_regs[dst] = res;
        m_pc = npc;
    endtask

    initial forever begin
        @(posedge clock);
        if (reset) begin
            model_reset();
            model_ok = 1;
        end else if (model_ok) begin
            model_exec();
        end
    end

    task automatic compare_cycle();
        logic [31:0] ins, ea;
        logic [5:0]  op;
        logic        exp_w, exp_r;
        int          bad;
        chk("pc", insMemAddress, m_pc);
        chk("insMemRead", {31'h0, insMemRead}, 32'd1);
        bad = -1;
        for (int i = 0; i < 32; i++) begin
            if (bad < 0 && dut.rf.data[i] !== m_regs[i]) bad = i;
        end
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL regfile r%0d: got %h expected %h", bad, dut.rf.data[bad], m_regs[bad]);
        end
        ins   = imem_at(m_pc);
        op    = ins[31:26];
        ea    = m_regs[ins[25:21]] + {{16{ins[15]}}, ins[15:0]};
        exp_w = !reset && (op == 6'h2B);
        exp_r = !reset && (op == 6'h23);
        chk("dataMemWrite", {31'h0, dataMemWrite}, {31'h0, exp_w});
        chk("dataMemRead", {31'h0, dataMemRead}, {31'h0, exp_r});
        if (exp_w || exp_r) chk("dataMemAddress", dataMemAddress, ea);
        if (exp_w) chk("dataWriteValue", dataWriteValue, m_regs[ins[20:16]]);
`ifdef STATUS_FLAGS_EN
        begin
            logic [3:0] ef;
            ef = 4'h0;
            ef[STATUS_V_BIT] = m_v;
            ef[STATUS_N_BIT] = m_n;
            ef[STATUS_Z_BIT] = m_z;
            ef[STATUS_C_BIT] = m_c;
            chk("status_reg", {28'h0, dut.status_reg}, {28'h0, ef});
        end
`endif
    endtask

    initial forever begin
        @(negedge clock);
        if (model_ok) compare_cycle();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 128; i++) imem[i] = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        clear_imem();
        // Program A: arithmetic, memory, flags, shifts, compares, NOP
        imem[0]  = 32'h20090005; // addi $t1,$zero,5
        imem[1]  = 32'h200A0007; // addi $t2,$zero,7
        imem[2]  = 32'h012a5820; // add  $t3,$t1,$t2
        imem[3]  = 32'h2008FFFF; // addi $t0,$zero,-1
        imem[4]  = 32'h3C101001; // lui  $s0,0x1001
        imem[5]  = 32'hAE080004; // sw   $t0,4($s0)
        imem[6]  = 32'h8E090004; // lw   $t1,4($s0)
        imem[7]  = 32'h20000005; // addi $zero,$zero,5
        imem[8]  = 32'h3C0C7FFF; // lui  $t4,0x7FFF
        imem[9]  = 32'h358CFFFF; // ori  $t4,$t4,0xFFFF
        imem[10] = 32'h200D0001; // addi $t5,$zero,1
        imem[11] = 32'h018D7020; // add  $t6,$t4,$t5
        imem[12] = 32'h01084022; // sub  $t0,$t0,$t0
        imem[13] = 32'h00097903; // sra  $t7,$t1,4
        imem[14] = 32'h012A882A; // slt  $s1,$t1,$t2
        imem[15] = 32'h012A902B; // sltu $s2,$t1,$t2
        imem[16] = 32'h01499806; // srlv $s3,$t1,$t2
        imem[17] = 32'hFC000000; // undefined opcode
        imem[18] = 32'h3954FFFF; // xori $s4,$t2,0xFFFF
        tick(2);
        chk("reset pc", dut.pc, 32'h00400000);
        chk("reset sp", dut.rf.data[sp], 32'h100103FC);
        chk("reset t0", dut.rf.data[t0], 32'h0);
        chk("reset ra", dut.rf.data[ra], 32'h0);
`ifdef STATUS_FLAGS_EN
        chk("reset status", {28'h0, dut.status_reg}, 32'h0);
`endif
        reset = 1'b0;
        tick(3);
        chk("add t3", dut.rf.data[t3], 32'h0000000C);
        chk("add pc", dut.pc, 32'h0040000C);
`ifdef STATUS_FLAGS_EN
        chk("add Z", {31'h0, dut.status_reg[STATUS_Z_BIT]}, 32'd0);
        chk("add N", {31'h0, dut.status_reg[STATUS_N_BIT]}, 32'd0);
`endif
        tick(2);
        chk("sw write", {31'h0, dataMemWrite}, 32'd1);
        chk("sw addr", dataMemAddress, 32'h10010004);
        chk("sw data", dataWriteValue, 32'hFFFFFFFF);
        tick(2);
        chk("lw t1", dut.rf.data[t1], 32'hFFFFFFFF);
        tick(1);
        chk("zero reg", dut.rf.data[zero], 32'h0);
        tick(4);
        chk("ovf add t6", dut.rf.data[t6], 32'h80000000);
`ifdef STATUS_FLAGS_EN
        chk("ovf V", {31'h0, dut.status_reg[STATUS_V_BIT]}, 32'd1);
        chk("ovf N", {31'h0, dut.status_reg[STATUS_N_BIT]}, 32'd1);
        chk("ovf C", {31'h0, dut.status_reg[STATUS_C_BIT]}, 32'd0);
`endif
        tick(1);
        chk("sub t0", dut.rf.data[t0], 32'h0);
`ifdef STATUS_FLAGS_EN
        chk("sub Z", {31'h0, dut.status_reg[STATUS_Z_BIT]}, 32'd1);
`endif
        tick(6);
        chk("sra t7", dut.rf.data[t7], 32'hFFFFFFFF);
        chk("slt s1", dut.rf.data[s1], 32'd1);
        chk("sltu s2", dut.rf.data[s2], 32'd0);
        chk("srlv s3", dut.rf.data[s3], 32'h01FFFFFF);
        chk("xori s4", dut.rf.data[s4], 32'h0000FFF8);
        chk("nop pc", dut.pc, 32'h0040004C);
        tick(3);

        // Program B: branches and jumps
        reset = 1'b1;
        clear_imem();
        imem[0]  = 32'h11080002; // beq  $t0,$t0,+2
        imem[1]  = 32'h20090099; // skipped
        imem[2]  = 32'h20090099; // skipped
        imem[3]  = 32'h15080005; // bne  $t0,$t0,+5 (not taken)
        imem[4]  = 32'h0C100040; // jal  0x00400100
        imem[5]  = 32'h20080003; // addi $t0,$zero,3
        imem[6]  = 32'h08100008; // j    0x00400020
        imem[7]  = 32'h20090099; // skipped
        imem[64] = 32'h03E00008; // jr   $ra
        tick(2);
        reset = 1'b0;
        #1;
        chk("beq nextPC", dut.reg_nextPC, 32'h0040000C);
        tick(1);
        chk("beq pc", dut.pc, 32'h0040000C);
        chk("bne nextPC", dut.reg_nextPC, 32'h00400010);
        tick(2);
        chk("jal pc", dut.pc, 32'h00400100);
        chk("jal ra", dut.rf.data[ra], 32'h00400014);
        tick(1);
        chk("jr pc", dut.pc, 32'h00400014);
        tick(2);
        chk("j pc", dut.pc, 32'h00400020);
        chk("j skip t1", dut.rf.data[t1], 32'h0);
        chk("j t0", dut.rf.data[t0], 32'd3);
        tick(2);

        // Program C: reset arriving while a store is pending
        reset = 1'b1;
        clear_imem();
        imem[0] = 32'h20080055; // addi $t0,$zero,0x55
        imem[1] = 32'hAFA80000; // sw   $t0,0($sp)
        imem[2] = 32'h8FAA0000; // lw   $t2,0($sp)
        tick(2);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        #1;
        chk("reset blocks sw", {31'h0, dataMemWrite}, 32'd0);
        tick(1);
        chk("mid reset pc", dut.pc, 32'h00400000);
        chk("mid reset t0", dut.rf.data[t0], 32'h0);
        chk("mid reset mem", dmem[255], 32'h0);
        reset = 1'b0;
        tick(3);
        chk("after sw mem", dmem[255], 32'h00000055);
        chk("lw t2", dut.rf.data[t2], 32'h00000055);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
